// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN datapath controllers.
// Contents:
//   state_t       - controller FSM state encoding
//   DRAIN_CYCLES  - cycles spent waiting for the last pixel to clear the
//                   memory and line-buffer pipeline
//   WIN_MAX       - saturation value of the 16-bit window counter
//   sat_inc16()   - saturating increment for 16-bit counters
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          DRAIN_CYCLES = 2;
  localparam logic [15:0] WIN_MAX      = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == WIN_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Memory-read and line-buffer bundle of the convolution window controller.
// Signals:
//   mem_rd_en / mem_addr  - read strobe and address towards feature-map memory
//   mem_rd_data           - read data, valid one cycle after mem_rd_en
//   lb_clear              - line-buffer reset
//   lb_valid_in/data_in   - pixel push into the line buffer
//   lb_valid_out          - window-valid pulse coming back from the line buffer
// Modports: master = controller side, slave = memory / line-buffer side.
interface conv_window_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  lb_clear;
  logic                  lb_valid_in;
  logic [DATA_WIDTH-1:0] lb_data_in;
  logic                  lb_valid_out;

  modport master (
    output mem_rd_en, mem_addr, lb_clear, lb_valid_in, lb_data_in,
    input  mem_rd_data, lb_valid_out
  );

  modport slave (
    input  mem_rd_en, mem_addr, lb_clear, lb_valid_in, lb_data_in,
    output mem_rd_data, lb_valid_out
  );

endinterface

// File: rtl/conv_window_ctrl.sv
// Convolution window controller: streams one WIDTH x WIDTH feature map from
// memory into an external line buffer and counts the windows it returns.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, abort        - frame request / frame cancel
//   base_addr           - address of pixel (0,0), latched on accepted start
//   out_ready           - downstream back-pressure; gates memory reads
//   bus (master)        - memory read port and line-buffer interface
//   busy, done          - frame in progress / 1-cycle completion pulse
//   win_count           - windows seen in the current or last frame
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; win_count holds last frame's total
// ST_CLEAR | one cycle of lb_clear before the first pixel
// ST_FEED  | one read per out_ready cycle, WIDTH*WIDTH reads in total
// ST_DRAIN | DRAIN_CYCLES cycles for the last pixel to reach the line buffer
// ST_DONE  | one-cycle done pulse
module conv_window_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  out_ready,
  conv_window_ctrl_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           win_count
);

  localparam int NPIX  = WIDTH * WIDTH;
  localparam int PIX_W = $clog2(NPIX + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(NPIX - 1);
  localparam logic [DRN_W-1:0] DRN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [PIX_W-1:0]      pix_cnt;
  logic [DRN_W-1:0]      drain_cnt;
  logic                  lb_vin_q;
  logic [15:0]           win_q;
  logic                  rd_fire;
  logic                  clear_c;

  // abort suppresses the read in its own cycle so no request is left
  // dangling once the frame is dropped.
  assign rd_fire = (state_q == ST_FEED) && out_ready && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_CLEAR;
        ST_CLEAR: state_d = ST_FEED;
        ST_FEED:  if (rd_fire && (pix_cnt == PIX_LAST)) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_cnt == '0) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE) && !abort;
    // The line buffer is also held cleared for the whole reset.
    clear_c = rst || (state_q == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      pix_cnt   <= '0;
      drain_cnt <= '0;
      lb_vin_q  <= 1'b0;
      win_q     <= '0;
    end else begin
      // A pending push still completes after abort: lb_vin_q is never killed.
      lb_vin_q <= rd_fire;

      if ((state_q == ST_IDLE) && start) begin
        base_q  <= base_addr;
        pix_cnt <= '0;
        win_q   <= '0;
      end else begin
        if (rd_fire) pix_cnt <= pix_cnt + 1'b1;
        if (busy && bus.lb_valid_out) win_q <= sat_inc16(win_q);
      end

      if ((state_q == ST_FEED) && (state_d == ST_DRAIN)) begin
        drain_cnt <= DRN_LOAD;
      end else if ((state_q == ST_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

  // Address wraps naturally modulo 2^ADDR_WIDTH.
  assign bus.mem_rd_en   = rd_fire;
  assign bus.mem_addr    = base_q + ADDR_WIDTH'(pix_cnt);
  assign bus.lb_clear    = clear_c;
  assign bus.lb_valid_in = lb_vin_q;
  assign bus.lb_data_in  = bus.mem_rd_data;
  assign win_count       = win_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl (WIDTH=5, ADDR_WIDTH=16).
module tb_conv_window_ctrl;

  localparam int DW    = 32;
  localparam int W     = 5;
  localparam int AW    = 16;
  localparam int NPIX  = W * W;
  localparam int DRAIN = 2;

  localparam int M_NORMAL  = 0;
  localparam int M_STALL   = 1;
  localparam int M_ABORT   = 2;
  localparam int M_RESTART = 3;
  localparam int M_RST     = 4;
  localparam int M_RAND    = 5;
  localparam int M_IDLE    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          out_ready;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic [15:0]   win_count;

  conv_window_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  conv_window_ctrl #(.DATA_WIDTH(DW), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .out_ready (out_ready),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .win_count (win_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Feature-map memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? mem_fn(bus.mem_addr) : DW'($urandom);

  int checks = 0;
  int errors = 0;
  int tcyc   = -1;

  // Reference model: frame progress in terms of reads done and cycles since
  // the last read, not FSM states.
  bit          m_active;
  int          m_age;
  int          m_reads;
  int          m_tail;
  logic [AW-1:0] m_base;
  logic [15:0] m_win;
  bit          m_prev_rd;
  logic [AW-1:0] m_prev_addr;

  int t_nrd, t_rd_stalled, t_first_rd, t_last_rd, t_nclear, t_clear;
  int t_ndone, t_done, t_busy_first, t_busy_last, t_lbv_first, t_lbv_last;
  logic [AW-1:0] t_first_addr, t_last_addr;
  logic [15:0]   t_win1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic model_reset();
    m_active    = 0;
    m_age       = 0;
    m_reads     = 0;
    m_tail      = 0;
    m_base      = '0;
    m_win       = '0;
    m_prev_rd   = 0;
    m_prev_addr = '0;
  endtask

  task automatic compare_cycle();
    bit e_rd, e_clear, e_done;
    logic [AW-1:0] e_addr;
    if (rst) begin
      chk("rst_busy",        busy,            0);
      chk("rst_done",        done,            0);
      chk("rst_mem_rd_en",   bus.mem_rd_en,   0);
      chk("rst_lb_valid_in", bus.lb_valid_in, 0);
      chk("rst_lb_clear",    bus.lb_clear,    1);
      chk("rst_mem_addr",    bus.mem_addr,    0);
      chk("rst_win_count",   win_count,       0);
      chk("rst_lb_data_in",  bus.lb_data_in,  bus.mem_rd_data);
      model_reset();
      return;
    end

    e_clear = m_active && (m_age == 1);
    e_rd    = m_active && (m_age >= 2) && (m_reads < NPIX) && out_ready && !abort;
    e_addr  = AW'(m_base + AW'(m_reads));
    e_done  = m_active && (m_reads == NPIX) && (m_tail == DRAIN + 1) && !abort;

    chk("busy",        busy,            m_active);
    chk("lb_clear",    bus.lb_clear,    e_clear);
    chk("mem_rd_en",   bus.mem_rd_en,   e_rd);
    chk("done",        done,            e_done);
    chk("lb_valid_in", bus.lb_valid_in, m_prev_rd);
    chk("win_count",   win_count,       m_win);
    if (e_rd)      chk("mem_addr",   bus.mem_addr,   e_addr);
    if (m_prev_rd) chk("lb_data_in", bus.lb_data_in, mem_fn(m_prev_addr));

    if (tcyc == 0) begin
      t_nrd = 0; t_rd_stalled = 0; t_first_rd = -1; t_last_rd = -1;
      t_nclear = 0; t_clear = -1; t_ndone = 0; t_done = -1;
      t_busy_first = -1; t_busy_last = -1; t_lbv_first = -1; t_lbv_last = -1;
      t_first_addr = '0; t_last_addr = '0; t_win1 = '1;
    end
    if (bus.mem_rd_en) begin
      if (t_first_rd < 0) begin
        t_first_rd   = tcyc;
        t_first_addr = bus.mem_addr;
      end
      t_last_rd   = tcyc;
      t_last_addr = bus.mem_addr;
      t_nrd++;
      if (!out_ready) t_rd_stalled++;
    end
    if (bus.lb_clear) begin t_nclear++; t_clear = tcyc; end
    if (bus.lb_valid_in) begin
      if (t_lbv_first < 0) t_lbv_first = tcyc;
      t_lbv_last = tcyc;
    end
    if (done) begin t_ndone++; t_done = tcyc; end
    if (busy) begin
      if (t_busy_first < 0) t_busy_first = tcyc;
      t_busy_last = tcyc;
    end
    if (tcyc == 1) t_win1 = win_count;

    // Advance model across the coming clock edge.
    if (m_active && bus.lb_valid_out && (m_win != 16'hFFFF)) m_win = m_win + 16'd1;
    m_prev_rd = e_rd;
    if (e_rd) m_prev_addr = e_addr;
    if (m_active && abort) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_age = 1; m_reads = 0; m_tail = 0;
        m_base = base_addr; m_win = '0;
      end
    end else begin
      m_age++;
      if ((m_reads == NPIX) && (m_tail == DRAIN + 1)) m_active = 0;
      else if (m_reads == NPIX) m_tail++;
      else if (e_rd) begin
        m_reads++;
        if (m_reads == NPIX) m_tail = 1;
      end
    end
  endtask

  task automatic run(input logic [AW-1:0] base, input int ncyc, input int mode);
    for (int t = 0; t < ncyc; t++) begin
      tcyc  = t;
      start = ((t == 0) && (mode != M_IDLE)) ||
              ((mode == M_RESTART) && ((t == 5) || (t == 20))) ||
              ((mode == M_RAND) && ($urandom_range(0, 29) == 0));
      abort = ((mode == M_ABORT) && (t == 8)) ||
              ((mode == M_RAND) && ($urandom_range(0, 119) == 0));
      if (mode == M_STALL)     out_ready = !((t >= 10) && (t <= 14));
      else if (mode == M_RAND) out_ready = ($urandom_range(0, 3) != 0);
      else                     out_ready = 1'b1;
      base_addr        = (t == 0) ? base : AW'($urandom);
      bus.lb_valid_out = 1'($urandom_range(0, 1));
      if ((mode == M_RST) && (t == 15)) rst = 1'b0;
      if ((mode == M_RST) && (t == 12)) begin
        rst = 1'b1;
        #1;
        chk("async_busy",        busy,            0);
        chk("async_done",        done,            0);
        chk("async_mem_rd_en",   bus.mem_rd_en,   0);
        chk("async_lb_valid_in", bus.lb_valid_in, 0);
        chk("async_lb_clear",    bus.lb_clear,    1);
        chk("async_mem_addr",    bus.mem_addr,    0);
        chk("async_win_count",   win_count,       0);
      end
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; bus.lb_valid_out = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      compare_cycle();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal frame.
    run(16'h0100, 32, M_NORMAL);
    chk("s1_clear_cyc",   t_clear,      1);
    chk("s1_nclear",      t_nclear,     1);
    chk("s1_nreads",      t_nrd,        25);
    chk("s1_first_rd",    t_first_rd,   2);
    chk("s1_last_rd",     t_last_rd,    26);
    chk("s1_first_addr",  t_first_addr, 16'h0100);
    chk("s1_last_addr",   t_last_addr,  16'h0118);
    chk("s1_lbv_first",   t_lbv_first,  3);
    chk("s1_lbv_last",    t_lbv_last,   27);
    chk("s1_done_cyc",    t_done,       29);
    chk("s1_ndone",       t_ndone,      1);
    chk("s1_busy_first",  t_busy_first, 1);
    chk("s1_busy_last",   t_busy_last,  29);

    // Back-pressure for cycles 10..14.
    run(16'h0100, 38, M_STALL);
    chk("s2_nreads",      t_nrd,        25);
    chk("s2_rd_stalled",  t_rd_stalled, 0);
    chk("s2_last_rd",     t_last_rd,    31);
    chk("s2_last_addr",   t_last_addr,  16'h0118);
    chk("s2_done_cyc",    t_done,       34);

    // Abort at cycle 8, then a fresh frame.
    run(16'h0200, 14, M_ABORT);
    chk("s3_busy_last",   t_busy_last,  8);
    chk("s3_nreads",      t_nrd,        6);
    chk("s3_last_addr",   t_last_addr,  16'h0205);
    chk("s3_ndone",       t_ndone,      0);
    run(16'h0300, 32, M_NORMAL);
    chk("s3b_nclear",     t_nclear,     1);
    chk("s3b_clear_cyc",  t_clear,      1);
    chk("s3b_win_at1",    t_win1,       0);
    chk("s3b_ndone",      t_ndone,      1);

    // Start pulses mid-frame are ignored.
    run(16'h0100, 32, M_RESTART);
    chk("s4_ndone",       t_ndone,      1);
    chk("s4_done_cyc",    t_done,       29);
    chk("s4_nclear",      t_nclear,     1);
    chk("s4_nreads",      t_nrd,        25);

    // Asynchronous reset mid-frame, then recovery.
    run(16'h0100, 24, M_RST);
    chk("s5_ndone",       t_ndone,      0);
    chk("s5_busy_last",   t_busy_last,  11);
    chk("s5_nreads",      t_nrd,        10);
    run(16'h0040, 32, M_NORMAL);
    chk("s5b_ndone",      t_ndone,      1);
    chk("s5b_done_cyc",   t_done,       29);

    // Address wrap.
    run(16'hFFF0, 32, M_NORMAL);
    chk("s6_first_addr",  t_first_addr, 16'hFFF0);
    chk("s6_last_addr",   t_last_addr,  16'h0008);
    chk("s6_nreads",      t_nrd,        25);
    chk("s6_done_cyc",    t_done,       29);

    // Randomised traffic against the model.
    repeat (10) run(AW'($urandom), 70, M_RAND);
    run(16'h0000, 60, M_IDLE);
    chk("final_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning pixel width.
REQ-002 SHALL have parameter WIDTH, default 5, meaning the square feature-map side in pixels (minimum 3).
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning the feature-map memory address width.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, reset: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit, frame start request.
REQ-007 SHALL have port abort, input, 1 bit, cancels the current frame.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH bits, address of pixel (0,0), sampled on an accepted start.
REQ-009 SHALL have port out_ready, input, 1 bit, downstream can accept windows.
REQ-010 SHALL have port mem_rd_en, output, 1 bit, memory read strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_WIDTH bits, read address.
REQ-012 SHALL have port mem_rd_data, input, DATA_WIDTH bits, read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port lb_clear, output, 1 bit, drives the line-buffer reset.
REQ-014 SHALL have port lb_valid_in, output, 1 bit, line-buffer push.
REQ-015 SHALL have port lb_data_in, output, DATA_WIDTH bits, line-buffer pixel.
REQ-016 SHALL have port lb_valid_out, input, 1 bit, window-valid pulse returned from the line buffer.
REQ-017 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-018 SHALL have port done, output, 1 bit, 1-cycle frame-complete pulse.
REQ-019 SHALL have port win_count, output, 16 bits, number of lb_valid_out pulses seen in the current or last frame.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-021 SHALL, in IDLE, on start=1: latch base_addr, zero the pixel counter and win_count, and go to CLEAR; start in any other state SHALL be ignored.
REQ-022 SHALL hold CLEAR for exactly 1 cycle with lb_clear=1, then go to FEED; lb_clear SHALL be 0 in all other states.
REQ-023 SHALL, in FEED, assert mem_rd_en in a cycle only when out_ready=1, with mem_addr = base + pix_cnt, and increment pix_cnt (width ceil(log2(WIDTH*WIDTH+1))) on each read.
REQ-024 SHALL, in FEED, drive mem_rd_en=0 and hold pix_cnt and mem_addr when out_ready=0.
REQ-025 SHALL go from FEED to DRAIN in the cycle after the read with pix_cnt = WIDTH*WIDTH-1 is issued.
REQ-026 SHALL register lb_valid_in as mem_rd_en delayed by 1 cycle and pass lb_data_in = mem_rd_data combinationally, aligned with lb_valid_in.
REQ-027 SHALL stay in DRAIN for exactly 2 cycles, then go to DONE.
REQ-028 SHALL, in DONE, assert done=1 for 1 cycle, then go to IDLE.
REQ-029 SHALL increment win_count on every lb_valid_out=1 while busy, saturating at 16'hFFFF, and hold its value in IDLE.
REQ-030 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with mem_rd_en=0 and no done pulse; a pending lb_valid_in SHALL still complete; abort SHALL take priority over every other transition.
REQ-031 SHALL allow the downstream to receive up to 2 further windows after it deasserts out_ready (1 memory latency + 1 line-buffer latency), and SHALL NOT provide its own skid buffer.
REQ-032 SHALL compute mem_addr modulo 2^ADDR_WIDTH (wrap, no error).

Reset
REQ-033 SHALL, while rst=1, force state IDLE and mem_rd_en, lb_valid_in, done, busy and win_count to 0, with lb_clear=1, mem_addr=0 and lb_data_in following mem_rd_data.
REQ-034 SHALL, on rst mid-frame, drop the frame with no done pulse.

Structure
REQ-035 SHALL take the FSM state encoding and the DRAIN_CYCLES=2 constant from the shared cnn_ctrl_pkg package.
REQ-036 SHALL be flat, with no sub-module; the line buffer SHALL be instantiated by the parent, not inside this block.

Verification
REQ-037 SHALL cover: WIDTH=5, base=0x0100, out_ready=1, start at cycle 0 -> lb_clear=1 at cycle 1, 25 reads at cycles 2..26 with addresses 0x0100..0x0118, lb_valid_in at cycles 3..27, done=1 at cycle 29, busy=1 at cycles 1..29.
REQ-038 SHALL cover: out_ready=0 for cycles 10..14 -> no mem_rd_en in those cycles, addresses contiguous with no skips or repeats, done delayed by 5 cycles to cycle 34.
REQ-039 SHALL cover: abort at cycle 8 -> busy=0 at cycle 9, exactly 6 reads issued, done never asserted; next start -> new lb_clear pulse and win_count restarts at 0.
REQ-040 SHALL cover: start pulsed at cycles 5 and 20 during a frame -> both ignored, exactly one done pulse.
REQ-041 SHALL cover: rst asserted at cycle 12 -> all outputs at reset values immediately (asynchronous), state IDLE after rst is released.
REQ-042 SHALL cover: base=0xFFF0 -> addresses wrap from 0xFFFF to 0x0000..0x0008.
